branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, PC/target width.
REQ-003 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  branch request present.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid&&in_ready.
REQ-007 SHALL have port funct3  input  3  RV32I branch encoding.
REQ-008 SHALL have ports operand_a, operand_b  input  DATA_WIDTH  rs1/rs2 values.
REQ-009 SHALL have ports pc, imm  input  ADDR_WIDTH  branch PC, sign-extended B-immediate.
REQ-010 SHALL have port pred_taken  input  1  fetch-stage prediction.
REQ-011 SHALL have port flush  input  1  kill in-flight and incoming request.
REQ-012 SHALL have ports out_valid output 1, out_ready input 1  result handshake.
REQ-013 SHALL have ports out_taken, out_mispredict, out_misaligned, out_illegal  output  1 each  resolved flags.
REQ-014 SHALL have port out_next_pc  output  ADDR_WIDTH  architecturally correct next PC.

Function
REQ-015 Decode: 000 BEQ, 001 BNE, 100 BLT, 101 BGE (signed); 110 BLTU, 111 BGEU (unsigned).
REQ-016 Signed decisions SHALL use Greater/Equal/Less of an instantiated ALU_Comparator; unsigned SHALL use a local unsigned compare.
REQ-017 funct3 010/011 SHALL give out_illegal=1, out_taken=0, out_mispredict=0, out_next_pc=pc+4.
REQ-018 Taken target = pc+imm, not-taken = pc+4, both modulo 2^ADDR_WIDTH (wrap, no error).
REQ-019 out_mispredict = out_taken XOR pred_taken for legal funct3.
REQ-020 out_misaligned = out_taken && target[1:0]!=0; out_next_pc still carries the target.
REQ-021 One result register; latency exactly 1 cycle from acceptance to out_valid.
REQ-022 in_ready = !out_valid || out_ready (combinational); back-to-back throughput 1/cycle.
REQ-023 Output fields SHALL hold stable while out_valid && !out_ready.
REQ-024 flush SHALL clear out_valid next edge and block capture that cycle; flush beats in_valid.
REQ-025 Result register states: EMPTY (out_valid=0) -> FULL on accept; FULL -> EMPTY on out_ready without accept; FULL -> FULL on simultaneous drain+accept; any -> EMPTY on flush.

Reset
REQ-026 rst_n low SHALL asynchronously force out_valid=0 and all out_* flags and out_next_pc to 0.
REQ-027 Reset mid-transaction SHALL discard the held result; no output after release until a new accept.
REQ-028 in_ready SHALL be 1 during and immediately after reset.

Configuration
REQ-029 Macro BRANCH_STATS_EN defined: add outputs stat_branches, stat_mispredicts (32 bits), counting each out_valid&&out_ready handshake (legal branches only / mispredicts), saturating at all-ones, cleared by rst_n.
REQ-030 Macro undefined: those ports and counters SHALL not exist; remaining behaviour identical.

Structure
REQ-031 Shared package SHALL hold funct3 branch encodings as an enum typedef, the resolved-result struct typedef, and constant PC_INCR=4.
REQ-032 ALU_Comparator SHALL be the only sub-module; all else inline.

Verification
REQ-033 BLT a=-655, b=3, pc=0x100, imm=0x20, pred=0 -> taken=1, next_pc=0x120, mispredict=1, next cycle.
REQ-034 BLTU a=0xFFFFFFFF, b=1 -> taken=0, next_pc=pc+4; BGE a=-11, b=-346 -> taken=1.
REQ-035 funct3=010 -> illegal=1, taken=0, mispredict=0; pc=0xFFFFFFFC not-taken -> next_pc=0x0.
REQ-036 out_ready=0 for 3 cycles with valid result -> in_ready=0, outputs stable; then drain+accept same cycle -> new result next cycle.
REQ-037 flush with in_valid=1 and a FULL register -> out_valid=0 next cycle, no capture; rst_n pulse while FULL -> out_valid=0 immediately.
REQ-038 With BRANCH_STATS_EN, 5 branches incl. 2 mispredicts drained -> stat_branches=5, stat_mispredicts=2.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Purpose : shared types and constants for the branch resolve unit.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: RV32I branch funct3 encodings, resolved-flag struct,
//           result-register state enum, sequential PC increment.
package branch_resolve_unit_pkg;

  // Distance from a branch to the instruction that follows it.
  localparam int unsigned PC_INCR = 4;

  // Legal RV32I branch encodings; 010 and 011 are reserved.
  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_funct3_e;

  // Resolved flags carried alongside the next PC.
  typedef struct packed {
    logic taken;
    logic mispredict;
    logic misaligned;
    logic illegal;
  } res_flags_t;

  // Occupancy of the single result register.
  typedef enum logic {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Purpose : request/result bundle between the issue logic and the branch
//           resolve unit.
// Latency : n/a (wiring only).
// Backpr. : in_valid/in_ready on the request side, out_valid/out_ready on
//           the result side; flush kills both.
// Modports: master = requester/consumer, slave = branch_resolve_unit.
interface branch_resolve_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  // Request side
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] imm;
  logic                  pred_taken;
  logic                  flush;

  // Result side
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_taken;
  logic                  out_mispredict;
  logic                  out_misaligned;
  logic                  out_illegal;
  logic [ADDR_WIDTH-1:0] out_next_pc;

  modport master (
    output in_valid, funct3, operand_a, operand_b, pc, imm, pred_taken,
           flush, out_ready,
    input  in_ready, out_valid, out_taken, out_mispredict, out_misaligned,
           out_illegal, out_next_pc
  );

  modport slave (
    input  in_valid, funct3, operand_a, operand_b, pc, imm, pred_taken,
           flush, out_ready,
    output in_ready, out_valid, out_taken, out_mispredict, out_misaligned,
           out_illegal, out_next_pc
  );

endinterface

// File: rtl/ALU_Comparator.sv
// Purpose : signed magnitude/equality compare of two operands.
// Latency : combinational.
// Backpr. : none.
// Ports   : a, b (WIDTH, two's complement) -> Greater, Equal, Less.
module ALU_Comparator #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             Greater,
  output logic             Equal,
  output logic             Less
);

  assign Equal   = (a == b);
  assign Less    = ($signed(a) < $signed(b));
  assign Greater = ($signed(a) > $signed(b));

endmodule

// File: rtl/branch_resolve_unit.sv
// Purpose : resolves RV32I conditional branches: taken decision, next PC,
//           mispredict / misaligned-target / illegal-encoding flags.
// Latency : 1 cycle from request acceptance to out_valid (one result register).
// Backpr. : in_ready = !out_valid || out_ready; result holds while stalled;
//           flush empties the register and blocks capture that cycle.
// Ports   : clk, rst_n (async, active low); bus = branch_resolve_unit_if.slave.
//           With BRANCH_STATS_EN defined: stat_branches, stat_mispredicts
//           (32-bit saturating handshake counters).
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_unit_if.slave bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
`endif
);

  typedef struct packed {
    res_flags_t            flags;
    logic [ADDR_WIDTH-1:0] next_pc;
  } result_t;

  // ---------------------------------------------------------------------
  // Comparison: signed via the comparator, unsigned locally.
  // ---------------------------------------------------------------------
  logic cmp_gt;
  logic cmp_eq;
  logic cmp_lt;
  logic cmp_ltu;

  ALU_Comparator #(
    .WIDTH (DATA_WIDTH)
  ) u_cmp (
    .a       (bus.operand_a),
    .b       (bus.operand_b),
    .Greater (cmp_gt),
    .Equal   (cmp_eq),
    .Less    (cmp_lt)
  );

  assign cmp_ltu = (bus.operand_a < bus.operand_b);

  // ---------------------------------------------------------------------
  // Decision and next-PC for the incoming request
  // ---------------------------------------------------------------------
  logic                  legal;
  logic                  taken;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] seq_pc;
  result_t               new_res;

  always_comb begin
    legal = 1'b1;
    taken = 1'b0;
    case (bus.funct3)
      F3_BEQ:  taken = cmp_eq;
      F3_BNE:  taken = !cmp_eq;
      F3_BLT:  taken = cmp_lt;
      F3_BGE:  taken = cmp_gt || cmp_eq;
      F3_BLTU: taken = cmp_ltu;
      F3_BGEU: taken = !cmp_ltu;
      default: legal = 1'b0;
    endcase

    // Both sums wrap modulo 2^ADDR_WIDTH by construction.
    target = bus.pc + bus.imm;
    seq_pc = bus.pc + ADDR_WIDTH'(PC_INCR);

    new_res                  = '0;
    new_res.flags.taken      = taken;
    new_res.flags.mispredict = legal && (taken ^ bus.pred_taken);
    // A misaligned target is still reported as next_pc so the trap
    // handler sees the faulting address.
    new_res.flags.misaligned = taken && (target[1:0] != 2'b00);
    new_res.flags.illegal    = !legal;
    new_res.next_pc          = taken ? target : seq_pc;
  end

  // ---------------------------------------------------------------------
  // Result register (EMPTY/FULL)
  // ---------------------------------------------------------------------
  res_state_e state_q;
  res_state_e state_d;
  result_t    res_q;
  result_t    res_d;
  logic       accept;
  logic       drain;

  assign bus.in_ready = (state_q == RES_EMPTY) || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  assign drain        = (state_q == RES_FULL) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    case (state_q)
      RES_EMPTY: begin
        if (accept) begin
          state_d = RES_FULL;
          res_d   = new_res;
        end
      end
      RES_FULL: begin
        // Accept while FULL implies out_ready: drain and refill together.
        if (accept) begin
          res_d = new_res;
        end else if (drain) begin
          state_d = RES_EMPTY;
        end
      end
      default: state_d = RES_EMPTY;
    endcase
    // Flush overrides everything, including a same-cycle request.
    if (bus.flush) begin
      state_d = RES_EMPTY;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RES_EMPTY;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
    end
  end

  assign bus.out_valid      = (state_q == RES_FULL);
  assign bus.out_taken      = res_q.flags.taken;
  assign bus.out_mispredict = res_q.flags.mispredict;
  assign bus.out_misaligned = res_q.flags.misaligned;
  assign bus.out_illegal    = res_q.flags.illegal;
  assign bus.out_next_pc    = res_q.next_pc;

`ifdef BRANCH_STATS_EN
  // ---------------------------------------------------------------------
  // Handshake statistics, saturating at all-ones
  // ---------------------------------------------------------------------
  logic [31:0] stat_br_q;
  logic [31:0] stat_br_d;
  logic [31:0] stat_mp_q;
  logic [31:0] stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (drain) begin
      if (!res_q.flags.illegal && (stat_br_q != '1)) begin
        stat_br_d = stat_br_q + 32'd1;
      end
      if (res_q.flags.mispredict && (stat_mp_q != '1)) begin
        stat_mp_d = stat_mp_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Purpose : self-checking bench for branch_resolve_unit: queue-based
//           reference model checked every cycle, plus directed literal checks.
// Latency : n/a.
// Backpr. : exercises stall, drain+accept, flush and reset-while-full.
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus();

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_resolve_unit #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        taken;
    logic        mis;
    logic        misal;
    logic        ill;
    logic [31:0] npc;
  } exp_t;

  exp_t q[$];

  function automatic exp_t resolve(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] pc,
                                   input logic [31:0] imm, input logic pred);
    exp_t        r;
    logic [31:0] tgt;
    r   = '0;
    tgt = pc + imm;
    case (f3)
      3'b000:  r.taken = (a == b);
      3'b001:  r.taken = (a != b);
      3'b100:  r.taken = ($signed(a) < $signed(b));
      3'b101:  r.taken = ($signed(a) >= $signed(b));
      3'b110:  r.taken = (a < b);
      3'b111:  r.taken = (a >= b);
      default: r.ill   = 1'b1;
    endcase
    r.mis   = !r.ill && (r.taken != pred);
    r.misal = r.taken && ((tgt % 4) != 0);
    r.npc   = r.taken ? tgt : pc + 32'd4;
    return r;
  endfunction

  // Holds at most one pending result; the head is what must be on the outputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q.delete();
    else if (bus.flush) q.delete();
    else if (q.size() == 0) begin
      if (bus.in_valid)
        q.push_back(resolve(bus.funct3, bus.operand_a, bus.operand_b,
                            bus.pc, bus.imm, bus.pred_taken));
    end else if (bus.out_ready) begin
      void'(q.pop_front());
      if (bus.in_valid)
        q.push_back(resolve(bus.funct3, bus.operand_a, bus.operand_b,
                            bus.pc, bus.imm, bus.pred_taken));
    end
  end

  always @(negedge clk) begin
    chk("mdl_in_ready", bus.in_ready, (q.size() == 0) || bus.out_ready);
    chk("mdl_out_valid", bus.out_valid, q.size() != 0);
    if (!rst_n) begin
      chk("mdl_rst_taken", bus.out_taken, 0);
      chk("mdl_rst_mis", bus.out_mispredict, 0);
      chk("mdl_rst_misal", bus.out_misaligned, 0);
      chk("mdl_rst_ill", bus.out_illegal, 0);
      chk("mdl_rst_npc", bus.out_next_pc, 0);
    end else if (q.size() != 0) begin
      chk("mdl_taken", bus.out_taken, q[0].taken);
      chk("mdl_mis", bus.out_mispredict, q[0].mis);
      chk("mdl_misal", bus.out_misaligned, q[0].misal);
      chk("mdl_ill", bus.out_illegal, q[0].ill);
      chk("mdl_npc", bus.out_next_pc, q[0].npc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    bus.funct3     = f3;
    bus.operand_a  = a;
    bus.operand_b  = b;
    bus.pc         = pc;
    bus.imm        = imm;
    bus.pred_taken = pred;
    bus.in_valid   = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic t, input logic m,
                            input logic ma, input logic il, input logic [31:0] npc);
    chk({tag, ".valid"}, bus.out_valid, 1);
    chk({tag, ".taken"}, bus.out_taken, t);
    chk({tag, ".mispredict"}, bus.out_mispredict, m);
    chk({tag, ".misaligned"}, bus.out_misaligned, ma);
    chk({tag, ".illegal"}, bus.out_illegal, il);
    chk({tag, ".next_pc"}, bus.out_next_pc, npc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.funct3     = 3'b000;
    bus.operand_a  = '0;
    bus.operand_b  = '0;
    bus.pc         = '0;
    bus.imm        = '0;
    bus.pred_taken = 1'b0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_next_pc", bus.out_next_pc, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Back-to-back requests, one result per cycle.
    set_req(3'b100, 32'hFFFFFD71, 32'd3, 32'h100, 32'h20, 1'b0); step();
    expect_out("blt_neg", 1, 1, 0, 0, 32'h120);
    set_req(3'b110, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1'b0); step();
    expect_out("bltu_big", 0, 0, 0, 0, 32'h204);
    set_req(3'b101, 32'hFFFFFFF5, 32'hFFFFFEA6, 32'h300, 32'h10, 1'b1); step();
    expect_out("bge_neg", 1, 0, 0, 0, 32'h310);
    set_req(3'b010, 32'd5, 32'd5, 32'h400, 32'h8, 1'b1); step();
    expect_out("illegal_010", 0, 0, 0, 1, 32'h404);
    set_req(3'b000, 32'd1, 32'd2, 32'hFFFFFFFC, 32'h40, 1'b0); step();
    expect_out("wrap_seq", 0, 0, 0, 0, 32'h0);
    set_req(3'b001, 32'd1, 32'd2, 32'h100, 32'h6, 1'b1); step();
    expect_out("misaligned", 1, 0, 1, 0, 32'h106);
    set_req(3'b000, 32'd7, 32'd7, 32'hFFFFFFF0, 32'h20, 1'b0); step();
    expect_out("wrap_target", 1, 1, 0, 0, 32'h10);
    set_req(3'b111, 32'd5, 32'd5, 32'h500, 32'hFFFFFFF0, 1'b1); step();
    expect_out("bgeu_eq", 1, 0, 0, 0, 32'h4F0);
    set_req(3'b100, 32'd3, 32'hFFFFFFFF, 32'h600, 32'h20, 1'b1); step();
    expect_out("blt_pos_neg", 0, 1, 0, 0, 32'h604);
    set_req(3'b101, 32'hFFFFFF00, 32'hFFFFFF00, 32'h700, 32'hC, 1'b1); step();
    expect_out("bge_eq", 1, 0, 0, 0, 32'h70C);
    set_req(3'b110, 32'd1, 32'hFFFFFFFF, 32'h800, 32'h8, 1'b0); step();
    expect_out("bltu_small", 1, 1, 0, 0, 32'h808);
    set_req(3'b011, 32'd0, 32'd0, 32'h900, 32'h8, 1'b0); step();
    expect_out("illegal_011", 0, 0, 0, 1, 32'h904);
    bus.in_valid = 1'b0; step();
    chk("drained_valid", bus.out_valid, 0);

    // Stall for 3 cycles, then drain and accept in the same cycle.
    bus.out_ready = 1'b0;
    set_req(3'b000, 32'd4, 32'd4, 32'h1000, 32'h100, 1'b1); step();
    expect_out("stall_a", 1, 0, 0, 0, 32'h1100);
    set_req(3'b001, 32'd4, 32'd4, 32'h2000, 32'h10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", bus.in_ready, 0);
      step();
      expect_out("stall_hold", 1, 0, 0, 0, 32'h1100);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", bus.in_ready, 1);
    step();
    expect_out("drain_accept_b", 0, 1, 0, 0, 32'h2004);
    bus.in_valid = 1'b0; step();
    chk("drained_b_valid", bus.out_valid, 0);

    // Flush beats a same-cycle request while FULL.
    bus.out_ready = 1'b0;
    set_req(3'b000, 32'd1, 32'd1, 32'h3000, 32'h20, 1'b1); step();
    expect_out("flush_pre", 1, 0, 0, 0, 32'h3020);
    set_req(3'b001, 32'd1, 32'd2, 32'h4000, 32'h40, 1'b1);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    step();
    chk("flush_valid", bus.out_valid, 0);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    step();
    chk("flush_no_capture", bus.out_valid, 0);

    // Reset pulse while FULL discards the held result immediately.
    bus.out_ready = 1'b0;
    set_req(3'b100, 32'hFFFFFFFF, 32'd0, 32'h5000, 32'h44, 1'b0); step();
    expect_out("rst_pre", 1, 1, 0, 0, 32'h5044);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_pulse_valid", bus.out_valid, 0);
    chk("rst_pulse_taken", bus.out_taken, 0);
    chk("rst_pulse_npc", bus.out_next_pc, 0);
    chk("rst_pulse_in_ready", bus.in_ready, 1);
    step();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("post_pulse_valid", bus.out_valid, 0);
    step();
    chk("post_pulse_valid2", bus.out_valid, 0);

`ifdef BRANCH_STATS_EN
    chk("stat_br_reset", stat_branches, 0);
    chk("stat_mp_reset", stat_mispredicts, 0);
    set_req(3'b000, 32'd1, 32'd1, 32'h100, 32'h10, 1'b1); step();
    set_req(3'b001, 32'd1, 32'd1, 32'h100, 32'h10, 1'b0); step();
    set_req(3'b100, 32'd1, 32'd2, 32'h100, 32'h10, 1'b0); step();
    set_req(3'b010, 32'd1, 32'd2, 32'h100, 32'h10, 1'b1); step();
    set_req(3'b110, 32'd2, 32'd1, 32'h100, 32'h10, 1'b0); step();
    set_req(3'b111, 32'd1, 32'd2, 32'h100, 32'h10, 1'b1); step();
    bus.in_valid = 1'b0; step();
    chk("stat_branches", stat_branches, 5);
    chk("stat_mispredicts", stat_mispredicts, 2);
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
